// File: rtl/io_bus_controller.sv
// io_bus_controller
//   Bridges CPU lw/sw accesses in the I/O window to four memory-mapped
//   devices (keypad, 7-seg, LED, switches). It stalls the CPU while a
//   device access is in flight. A missing dev_ack is bounded by a wait
//   counter. Address errors and timeouts raise a sticky error flag.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   io_read, io_write   level requests from the instruction decoder
//   addr[9:0]           byte address; valid window is addr[9:6] == 4'b0001
//   wdata[31:0]         store data, captured when a request is accepted
//   dev_ack             device completion strobe (used in ACCESS only)
//   dev_rdata[31:0]     device read data, valid with dev_ack
//   dev_sel[3:0]        one-hot device select during ACCESS
//   dev_rd, dev_wr      device read / write strobes during ACCESS
//   dev_wdata[31:0]     captured store data
//   io_rdata[31:0]      read result to the write-back mux
//   cpu_stall           freezes PC and register write while high
//   io_err              sticky error flag, cleared only by reset
module io_bus_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic [3:0]  dev_sel,
  output logic        dev_rd,
  output logic        dev_wr,
  output logic [31:0] dev_wdata,
  output logic [31:0] io_rdata,
  output logic        cpu_stall,
  output logic        io_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter value seen in the last ACCESS cycle that is allowed to wait.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        op_write_reg, op_write_next;
  logic [1:0]  dev_idx_reg, dev_idx_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic req_any;
  logic req_one;
  logic addr_ok;
  logic in_access;

  // addr[3:0] selects a byte inside a device slot and is not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[3:0];

  assign req_any   = io_read | io_write;
  assign req_one   = io_read ^ io_write;
  assign addr_ok   = (addr[9:6] == 4'b0001);
  assign in_access = (state_reg == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      dev_idx_reg  <= 2'd0;
      wdata_reg    <= 32'd0;
      cnt_reg      <= 8'd0;
      rdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_write_reg <= op_write_next;
      dev_idx_reg  <= dev_idx_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_write_next = op_write_reg;
    dev_idx_next  = dev_idx_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;

    case (state_reg)
      IDLE: begin
        if (req_one && addr_ok) begin
          state_next    = ACCESS;
          op_write_next = io_write;
          dev_idx_next  = addr[5:4];
          wdata_next    = wdata;
          cnt_next      = 8'd0;
        end else if (req_any) begin
          // Bad address or conflicting request: never touch a device.
          state_next = DONE;
          err_next   = 1'b1;
          rdata_next = 32'd0;
        end
      end
      ACCESS: begin
        // Saturating so the counter can never wrap back into range.
        if (cnt_reg != 8'hFF) begin
          cnt_next = cnt_reg + 8'd1;
        end
        // dev_ack is tested first so an ack on the last cycle still succeeds.
        if (dev_ack) begin
          state_next = DONE;
          if (!op_write_reg) begin
            rdata_next = dev_rdata;
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = DONE;
          err_next   = 1'b1;
          rdata_next = 32'd0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign dev_sel[gi] = in_access && (dev_idx_reg == 2'(gi));
    end
  endgenerate

  assign dev_rd    = in_access & ~op_write_reg;
  assign dev_wr    = in_access & op_write_reg;
  assign dev_wdata = wdata_reg;
  assign io_rdata  = rdata_reg;
  assign io_err    = err_reg;

  // rst_n gates the stall so a held request cannot freeze the CPU in reset.
  assign cpu_stall = rst_n & (((state_reg == IDLE) & req_any) | in_access);

endmodule

// File: tb/tb_io_bus_controller.sv
// Testbench for io_bus_controller (TIMEOUT_CYCLES = 8).
// Driver issues one instruction at a time and pushes the expected outcome,
// computed from the transaction rules, into a queue. A monitor observes
// each completed instruction (stall falling into the DONE cycle) and
// compares what it saw against the queued expectation.
module tb_io_bus_controller;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        dev_ack = 1'b0;
  logic [31:0] dev_rdata = '0;
  logic [3:0]  dev_sel;
  logic        dev_rd;
  logic        dev_wr;
  logic [31:0] dev_wdata;
  logic [31:0] io_rdata;
  logic        cpu_stall;
  logic        io_err;

  io_bus_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr      (addr),
    .wdata     (wdata),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata),
    .dev_sel   (dev_sel),
    .dev_rd    (dev_rd),
    .dev_wr    (dev_wr),
    .dev_wdata (dev_wdata),
    .io_rdata  (io_rdata),
    .cpu_stall (cpu_stall),
    .io_err    (io_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model + scoreboard queue ----------------
  typedef struct {
    int          n_stall;
    int          n_rd;
    int          n_wr;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  // ack_at: ACCESS cycle (1-based) in which the device acks; > T means never.
  task automatic model_push(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [31:0] wd, input int ack_at, input logic [31:0] rdv);
    exp_t e;
    int   n_acc;
    logic valid;
    valid   = (rd != wr) && (a[9:6] == 4'd1);
    e.wdata = wd;
    e.sel   = 4'b0000;
    e.n_rd  = 0;
    e.n_wr  = 0;
    if (!valid) begin
      e.n_stall   = 1;
      model_rdata = 32'd0;
      model_err   = 1'b1;
    end else begin
      n_acc     = (ack_at <= T) ? ack_at : T;
      e.n_stall = 1 + n_acc;
      e.sel     = 4'b0001 << a[5:4];
      if (rd) e.n_rd = n_acc;
      else    e.n_wr = n_acc;
      if (ack_at > T) begin
        model_rdata = 32'd0;
        model_err   = 1'b1;
      end else if (rd) begin
        model_rdata = rdv;
      end
    end
    e.rdata = model_rdata;
    e.err   = model_err;
    exp_q.push_back(e);
  endtask

  // ---------------- device responder ----------------
  int          cur_ack_at = 1000;
  logic [31:0] cur_rdata = '0;

  initial begin
    int acc_cnt;
    acc_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (dev_rd || dev_wr) begin
        acc_cnt++;
        dev_ack   = (acc_cnt == cur_ack_at);
        dev_rdata = dev_ack ? cur_rdata : $urandom;
      end else begin
        // Random noise outside ACCESS must be ignored by the DUT.
        acc_cnt   = 0;
        dev_ack   = 1'($urandom_range(0, 1));
        dev_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int          st, nr, nw, txn;
    logic [3:0]  so;
    logic [31:0] wseen;
    logic        wbad, prev;
    exp_t        e;
    st = 0; nr = 0; nw = 0; txn = 0; so = '0; wseen = '0; wbad = 1'b0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; nr = 0; nw = 0; so = '0; wbad = 1'b0; prev = 1'b0;
      end else if (cpu_stall) begin
        st++;
        if (dev_rd) nr++;
        if (dev_wr) begin
          nw++;
          if (nw > 1 && dev_wdata !== wseen) wbad = 1'b1;
          wseen = dev_wdata;
        end
        so   = so | dev_sel;
        prev = 1'b1;
      end else begin
        if (prev) begin
          txn++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: txn %0d completed with nothing expected", txn);
          end else begin
            e = exp_q.pop_front();
            check("stall_cycles", 32'(st), 32'(e.n_stall));
            check("rd_cycles", 32'(nr), 32'(e.n_rd));
            check("wr_cycles", 32'(nw), 32'(e.n_wr));
            check("dev_sel", 32'(so), 32'(e.sel));
            check("io_rdata", io_rdata, e.rdata);
            check("io_err", 32'(io_err), 32'(e.err));
            check("done_strobes", 32'({dev_rd, dev_wr, dev_sel}), 32'd0);
            if (e.n_wr > 0) begin
              check("dev_wdata", wseen, e.wdata);
              check("wdata_stable", 32'(wbad), 32'd0);
            end
            $display("txn %0d: stall=%0d rd=%0d wr=%0d sel=%b rdata=0x%08h err=%0b",
                     txn, st, nr, nw, so, io_rdata, io_err);
          end
        end
        st = 0; nr = 0; nw = 0; so = '0; wbad = 1'b0; prev = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT in IDLE; returns the same way.
  task automatic do_txn(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rdv);
    int c;
    model_push(rd, wr, a, wd, ack_at, rdv);
    cur_ack_at = ack_at;
    cur_rdata  = rdv;
    io_read    = rd;
    io_write   = wr;
    addr       = a;
    wdata      = wd;
    @(posedge clk);
    #1;
    // Address and data must be ignored once the request is accepted.
    addr  = 10'($urandom);
    wdata = $urandom;
    c = 0;
    while (cpu_stall && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (cpu_stall) begin
      n_checks++;
      $display("FAIL done_timeout: stall still high after %0d cycles", c);
    end
    io_read  = 1'b0;
    io_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  ra;
    logic [31:0] rv;
    int          r;
    logic        rr, rw;

    // Reset state, with both requests held high.
    io_read  = 1'b1;
    io_write = 1'b1;
    #12;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_sel", 32'(dev_sel), 32'd0);
    check("rst_strobes", 32'({dev_rd, dev_wr}), 32'd0);
    check("rst_wdata", dev_wdata, 32'd0);
    check("rst_rdata", io_rdata, 32'd0);
    check("rst_err", 32'(io_err), 32'd0);
    io_read  = 1'b0;
    io_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases; first one is issued right after release.
    do_txn(1'b1, 1'b0, 10'h070, 32'h0, 1, 32'h0000_00A5);      // switches read
    do_txn(1'b0, 1'b1, 10'h060, 32'h1234, 4, 32'h0);           // LED write
    do_txn(1'b1, 1'b0, 10'h050, 32'h0, T, 32'h5555_AAAA);      // ack on last cycle
    do_txn(1'b1, 1'b0, 10'h040, 32'h0, T - 1, 32'h0000_0001);  // keypad read
    do_txn(1'b0, 1'b1, 10'h080, 32'h77, 1, 32'h0);             // bad address
    do_txn(1'b1, 1'b1, 10'h070, 32'h99, 1, 32'h0);             // both requests
    do_txn(1'b1, 1'b0, 10'h040, 32'h0, 1000, 32'h0);           // timeout
    do_txn(1'b1, 1'b0, 10'h050, 32'h0, 2, 32'hDEAD_BEEF);      // error stays sticky

    // Reset pulled between edges in the middle of an ACCESS.
    cur_ack_at = 1000;
    io_read    = 1'b1;
    addr       = 10'h070;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rd", 32'(dev_rd), 32'd0);
    check("abort_sel", 32'(dev_sel), 32'd0);
    check("abort_stall", 32'(cpu_stall), 32'd0);
    check("abort_err", 32'(io_err), 32'd0);
    check("abort_rdata", io_rdata, 32'd0);
    check("abort_wdata", dev_wdata, 32'd0);
    io_read     = 1'b0;
    model_rdata = 32'd0;
    model_err   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 10'h050, 32'h0, 3, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      rr = (r == 0) || (r < 5);
      rw = (r == 0) || (r >= 5);
      if ($urandom_range(0, 4) == 0) ra = 10'($urandom);
      else ra = {4'b0001, 6'($urandom)};
      rv = $urandom;
      do_txn(rr, rw, ra, $urandom, int'($urandom_range(1, T + 2)), rv);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bus_controller.md
IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max ACCESS-state cycles waiting for dev_ack (range 1..255).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 io_read  in  1  level request from the instruction decoder: lw to the I/O window.
REQ-005 io_write  in  1  level request from the instruction decoder: sw to the I/O window.
REQ-006 addr  in  10  byte address bits [9:0] of the ALU result.
REQ-007 wdata  in  32  store data from the register file.
REQ-008 dev_ack  in  1  device completion strobe, sampled in ACCESS only.
REQ-009 dev_rdata  in  32  device read data, valid when dev_ack=1.
REQ-010 dev_sel  out  4  one-hot device select.
REQ-011 dev_rd / dev_wr  out  1 each  device read / write strobes.
REQ-012 dev_wdata  out  32  latched store data.
REQ-013 io_rdata  out  32  read result to the write-back mux.
REQ-014 cpu_stall  out  1  freezes PC and register write while high.
REQ-015 io_err  out  1  sticky error flag.

Function
REQ-016 Address map: accesses are valid only when addr[9:6]=4'b0001; device index = addr[5:4]. Device 0 is keypad (0x..C40), device 1 is 7-seg (0x..C50), device 2 is LED (0x..C60), device 3 is switches (0x..C70).
REQ-017 States: IDLE, ACCESS, DONE; encoding is free.
REQ-018 IDLE + exactly one of io_read/io_write + valid address -> capture op, device index and wdata, then ACCESS.
REQ-019 IDLE + request with invalid address, or both io_read and io_write high -> no device strobe; set io_err, io_rdata<=0, go to DONE.
REQ-020 ACCESS: dev_sel = one-hot(index); dev_rd or dev_wr held high per captured op; dev_wdata = captured wdata; wait counter increments each cycle.
REQ-021 ACCESS + dev_ack=1 -> io_rdata<=dev_rdata on a read; io_rdata unchanged on a write; go to DONE.
REQ-022 ACCESS + dev_ack=0 + counter=TIMEOUT_CYCLES-1 -> timeout: set io_err, io_rdata<=0, go to DONE.
REQ-023 When dev_ack coincides with the timeout cycle, dev_ack wins and no error is raised.
REQ-024 DONE: all dev_* strobes low, dev_sel=0; requests ignored; unconditional return to IDLE next cycle.
REQ-025 Wait counter is 8 bits, cleared on entry to ACCESS, and never wraps.
REQ-026 cpu_stall = (IDLE and (io_read or io_write)) or ACCESS, combinational; cpu_stall is low in DONE so the instruction retires at the end of DONE.
REQ-027 Latency: request seen in IDLE at cycle 0; dev_ack at cycle k≥1 -> DONE at cycle k+1; minimum 3 cycles per I/O instruction.
REQ-028 Inputs addr and wdata are ignored outside IDLE; dev_ack is ignored outside ACCESS.
REQ-029 io_err is cleared only by reset.

Reset
REQ-030 rst_n=0 -> immediately (no clock needed): state=IDLE, counter=0, dev_sel=0, dev_rd=0, dev_wr=0, dev_wdata=0, io_rdata=0, io_err=0.
REQ-031 While in reset, cpu_stall=0 regardless of io_read/io_write.
REQ-032 Reset asserted mid-ACCESS aborts the transfer with no DONE cycle; after release, the block starts in IDLE.
REQ-033 Release is synchronous to clk: the first request is accepted on the first rising edge with rst_n=1.

Verification
REQ-034 Stimulus: io_read, addr=0x070, dev_ack=1 in the first ACCESS cycle, dev_rdata=0x0000_00A5. Required: dev_sel=4'b1000, dev_rd high for 1 cycle, io_rdata=0xA5 in DONE, cpu_stall high for exactly 2 cycles.
REQ-035 Stimulus: io_write, addr=0x060, wdata=0x1234, dev_ack after 4 ACCESS cycles. Required: dev_sel=4'b0100, dev_wr high for 4 cycles, dev_wdata=0x1234, io_err=0.
REQ-036 Stimulus: TIMEOUT_CYCLES=8, io_read to 0x040, dev_ack never asserted. Required: DONE after 8 ACCESS cycles, io_rdata=0, io_err=1 and still 1 after a later good access.
REQ-037 Stimulus: io_write with addr=0x080; separately, io_read and io_write both high. Required: no dev_* strobe in either case, one stall cycle then DONE, io_err=1.
REQ-038 Stimulus: TIMEOUT_CYCLES=8, dev_ack=1 on the 8th ACCESS cycle. Required: successful completion with io_err=0.
REQ-039 Stimulus: rst_n pulled low during ACCESS between clock edges. Required: strobes and cpu_stall drop asynchronously; after release, a new read to 0x050 completes normally.
